// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit bitwise logic unit with valid/ready
// handshake, result status flags, accumulate mode and an accepted-op counter.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_NAND  = 3'd1,
        OP_OR    = 3'd2,
        OP_NOR   = 3'd3,
        OP_NOT_A = 3'd4,
        OP_XOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASS  = 3'd7
    } op_e;

    logic             accept_c;
    logic [WIDTH-1:0] operand_x_c;
    logic [WIDTH-1:0] result_c;
    logic             zero_c;
    logic             ones_c;
    logic             parity_c;

    // Ready depends only on registered state, clear and out_ready; never on in_valid.
    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept_c = in_valid && in_ready;

    // Second operand: last result register (consumed or not) in accumulate mode.
    always_comb begin
        operand_x_c = in_b;
        if (in_acc) begin
            operand_x_c = out_data;
        end
    end

    // Bitwise operation select.
    always_comb begin
        result_c = '0;
        case (op_e'(in_op))
            OP_AND:   result_c = in_a & operand_x_c;
            OP_NAND:  result_c = ~(in_a & operand_x_c);
            OP_OR:    result_c = in_a | operand_x_c;
            OP_NOR:   result_c = ~(in_a | operand_x_c);
            OP_NOT_A: result_c = ~in_a;
            OP_XOR:   result_c = in_a ^ operand_x_c;
            OP_XNOR:  result_c = ~(in_a ^ operand_x_c);
            OP_PASS:  result_c = in_a;
            default:  result_c = '0;
        endcase
    end

    // Status flags derived from the result about to be registered.
    always_comb begin
        zero_c   = (result_c == '0);
        ones_c   = &result_c;
        parity_c = ^result_c;
    end

    // Result, flags, valid and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_zero   <= 1'b1;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
            out_valid  <= 1'b0;
            op_count   <= '0;
        end else if (clear) begin
            out_data   <= '0;
            out_zero   <= 1'b1;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
            out_valid  <= 1'b0;
            op_count   <= '0;
        end else if (accept_c) begin
            out_data   <= result_c;
            out_zero   <= zero_c;
            out_ones   <= ones_c;
            out_parity <= parity_c;
            out_valid  <= 1'b1;
            op_count   <= op_count + CNT_W'(1);
        end else if (out_ready) begin
            // Result consumed; data and flags stay as the accumulator source.
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed scenarios plus randomized traffic, with a
// scoreboard queue of expected results checked by an independent monitor.
module tb_logic_unit_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             z;
        logic             o;
        logic             p;
        logic [CNT_W-1:0] c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_ones;
    logic             out_parity;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit               m_valid;
    logic [WIDTH-1:0] m_acc;
    logic [CNT_W-1:0] m_cnt;
    exp_t             sb[$];
    exp_t             mon_e;

    logic [WIDTH-1:0] ops_exp [8];

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operation table written directly from the op encoding.
    function automatic logic [WIDTH-1:0] ref_op(input int op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] x);
        case (op)
            0: return a & x;
            1: return ~(a & x);
            2: return a | x;
            3: return ~(a | x);
            4: return ~a;
            5: return a ^ x;
            6: return ~(a ^ x);
            default: return a;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_acc   = '0;
        m_cnt   = '0;
        sb.delete();
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic acc, input logic ordy, input logic clr);
        logic             exp_ready;
        logic             acc_ok;
        logic [WIDTH-1:0] r;
        exp_t             e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_acc    = acc;
        out_ready = ordy;
        clear     = clr;
        r         = '0;
        @(negedge clk);
        exp_ready = !clr && (!m_valid || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc_ok = v && exp_ready;
        if (acc_ok) begin
            r   = ref_op(int'(op), a, acc ? m_acc : b);
            e.d = r;
            e.z = (r == '0);
            e.o = (r == {WIDTH{1'b1}});
            e.p = 1'($countones(r) % 2);
            e.c = m_cnt + CNT_W'(1);
            sb.push_back(e);
        end
        @(posedge clk);
        if (clr) begin
            m_valid = 1'b0;
            m_acc   = '0;
            m_cnt   = '0;
            sb.delete();
        end else if (acc_ok) begin
            m_valid = 1'b1;
            m_acc   = r;
            m_cnt   = m_cnt + CNT_W'(1);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    // Monitor: every result handed downstream must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_unexpected: got data 0x%0h expected no output at %0t", out_data, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("mon_data",   32'(out_data),   32'(mon_e.d));
                chk("mon_zero",   32'(out_zero),   32'(mon_e.z));
                chk("mon_ones",   32'(out_ones),   32'(mon_e.o));
                chk("mon_parity", 32'(out_parity), 32'(mon_e.p));
                chk("mon_count",  32'(op_count),   32'(mon_e.c));
            end
        end
    end

    initial begin
        ops_exp = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h3A, 8'hFF, 8'h00, 8'hC5};
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_op = '0; in_acc = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Some traffic, then a mid-run asynchronous reset
        step(1'b1, 8'h12, 8'h34, 3'd2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h56, 8'h78, 3'd5, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'h00);
        chk("rst_zero",  32'(out_zero),  32'd1);
        chk("rst_ones",  32'(out_ones),  32'd0);
        chk("rst_count", 32'(op_count),  32'd0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // All eight ops back to back
        for (int op = 0; op < 8; op++) begin
            step(1'b1, 8'hC5, 8'h3A, 3'(op), 1'b0, 1'b1, 1'b0);
            chk("ops_data", 32'(out_data), 32'(ops_exp[op]));
            chk("ops_valid", 32'(out_valid), 32'd1);
            if (op == 0) chk("op0_zero", 32'(out_zero), 32'd1);
            if (op == 1) chk("op1_ones", 32'(out_ones), 32'd1);
            if (op == 7) chk("op7_parity", 32'(out_parity), 32'd0);
        end
        chk("ops_count", 32'(op_count), 32'd8);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

        // Backpressure
        step(1'b1, 8'h0F, 8'hF0, 3'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h33, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b0);
            chk("bp_data",  32'(out_data),  32'hFF);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        step(1'b1, 8'h33, 8'h0F, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("bp_second", 32'(out_data), 32'h03);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

        // Accumulate chain
        step(1'b1, 8'hFF, 8'h00, 3'd7, 1'b0, 1'b1, 1'b0);
        chk("acc_1", 32'(out_data), 32'hFF);
        step(1'b1, 8'h0F, 8'h00, 3'd5, 1'b1, 1'b1, 1'b0);
        chk("acc_2", 32'(out_data), 32'hF0);
        step(1'b1, 8'hF0, 8'h00, 3'd5, 1'b1, 1'b1, 1'b0);
        chk("acc_3", 32'(out_data), 32'h00);
        chk("acc_zero", 32'(out_zero), 32'd1);

        // Clear collides with pending result and new input
        step(1'b1, 8'h55, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_data",  32'(out_data),  32'h00);
        chk("clr_count", 32'(op_count),  32'd0);
        step(1'b1, 8'h00, 8'h00, 3'd4, 1'b1, 1'b1, 1'b0);
        chk("clr_after", 32'(out_data), 32'hFF);

        // Counter wrap
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(i), 8'h5A, 3'd5, 1'b0, 1'b1, 1'b0);
        end
        chk("wrap_count", 32'(op_count), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end

        // Drain
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
